dacctrl_rx: RTL and testbench
=============================

Name: dacctrl_rx

Overview:
- Receiver and decoder for the one-wire ADC DAC-control stream (ADC_DACCTRL) that the on-board DAC-control generator drives.
- Recovers 16-bit frames, validates the header, and maintains a shadow copy of the four 8-bit DAC registers.
- Flags malformed and stalled frames.
- Used as a bench-level DAC model and as an on-chip loopback monitor confirming the DAC was programmed to its minimum values.

Parameters:
- PSDAC, 8, transmitter prescale; nominal bit cell = 2^(PSDAC+1) clk.
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- TIMEOUT_CYCLES, 2^(PSDAC+2), max clk between cell-end edges inside a frame before abort.

Ports:
- clk  in  1  system clock, same frequency as the transmitter clock or faster.
- rst  in  1  synchronous reset, active-high.
- dacctrl_i  in  1  serial DAC-control line (may be asynchronous).
- frame_valid_o  out  1  one-cycle pulse: good frame decoded.
- frame_err_o  out  1  one-cycle pulse: header error or timeout.
- addr_o  out  2  register address of last good frame.
- data_o  out  8  data byte of last good frame.
- busy_o  out  1  frame in progress.
- regs_o  out  32  shadow regs; [8k+7:8k] = reg k.

Behaviour:
- Reset: all outputs 0; regs_o = 0; history and sync cleared; state IDLE; bit count 0.
- Line coding, per bit cell:
  - Data level for cell-2 clocks, then 1 for one clk, then 0 for one clk.
  - Exactly one falling edge per cell, at the cell end.
  - Line is 0 between frames.
- Front end:
  - SYNC_STAGES flops feed a 3-bit history h[2:0], where h[0] is newest.
  - cell_end = h[1] & ~h[0]; sampled bit = h[2].
  - A 1-clk high strobe must be caught, hence the clk >= tx-clk requirement.
- Frame: 16 bits, MSB first.
  - [15:11] must be 5'b11111.
  - [10:9] = addr.
  - [8] must be 1.
  - [7:0] = data.
- States: IDLE, SHIFT, CHECK.
  - IDLE: on cell_end, shift in bit, cnt=1, -> SHIFT; busy_o=1.
  - SHIFT: on cell_end, shift in and cnt++. When cnt reaches 16 -> CHECK.
  - SHIFT: timeout counter clears on each cell_end and increments otherwise. At TIMEOUT_CYCLES without an edge: frame_err_o pulse, discard, -> IDLE.
  - CHECK (1 cycle), header OK: write regs_o[addr], latch addr_o/data_o, pulse frame_valid_o.
  - CHECK, header bad: pulse frame_err_o only; regs, addr_o and data_o unchanged. Either way -> IDLE, busy_o=0.
- Latency: frame_valid_o/frame_err_o assert SYNC_STAGES+2 clk after the clk edge at which the final low of cell 16 is first sampled by sync stage 1. regs_o updates in that same cycle.
- Boundaries:
  - cell_end coincident with timeout expiry: edge wins, no error.
  - cell_end arriving during CHECK is not lost; it starts a new frame.
  - Line stuck high or low in IDLE: no activity, no error.
  - rst mid-frame: partial frame discarded, regs_o cleared, no pulses.
  - Repeated writes to the same address: last one wins.
  - frame_valid_o and frame_err_o are never high together.

Decomposition:
- Package dacctrl_pkg:
  - FRAME_W=16, HDR=5'b11111, HDR_W=5, ADDR_LSB=9, MARK_BIT=8.
  - State enum {IDLE, SHIFT, CHECK}.
  - Function cell_len(psdac).
- Sub-module dacctrl_rx_frontend: synchroniser, history register, cell_end and bit outputs.

Test Plan (bench transmitter model with PSDAC=2, cell=8 clk, TIMEOUT_CYCLES=16):
- Send 0xF9C0 -> frame_valid_o once, addr_o=0, data_o=0xC0, regs_o=0x000000C0, at the specified latency.
- Send 0xFB80, 0xFDC0, 0xFF80 back-to-back with no idle gap -> three valid pulses; regs_o=0x80C080C0 (plus reg0 from the prior frame kept).
- Send 0x79C0 (bad header) and 0xF8C0 (mark bit 0) -> frame_err_o twice, regs_o unchanged, no valid pulse.
- Send 7 cells, then hold the line low -> frame_err_o exactly 16 clk after the 7th cell_end; next full frame 0xFB55 decodes to addr 1, data 0x55.
- Assert rst after 10 cells of 0xFF80 -> all outputs 0; following 0xF9AA decodes cleanly, regs_o=0x000000AA.
- Jitter the cell length ±1 clk per cell with a frame of 0xFDC3 -> still decodes to addr 2, data 0xC3.

Source files
------------

// File: rtl/dacctrl_pkg.sv
// rtl/dacctrl_pkg.sv - shared constants, state type and helpers for the DAC-control receiver
package dacctrl_pkg;

    localparam int FRAME_W = 16;
    localparam int HDR_W = 5;
    localparam logic [HDR_W-1:0] HDR = 5'b11111;
    localparam int ADDR_LSB = 9;
    localparam int MARK_BIT = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } state_t;

    function automatic int cell_len(input int psdac);
        return 1 << (psdac + 1);
    endfunction

endpackage

// File: rtl/dacctrl_rx_frontend.sv
// rtl/dacctrl_rx_frontend.sv - line synchroniser, 3-deep history, cell-end and sampled-bit decode
module dacctrl_rx_frontend #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic cell_end,
    output logic sample_bit
);

    logic [SYNC_STAGES-1:0] sync;
    logic [2:0]             hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            hist <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], line};
            hist <= {hist[1:0], sync[SYNC_STAGES-1]};
        end
    end

    // The only falling edge in a cell follows the 1-clk high strobe, so the
    // level two samples before the edge is the data level of that cell.
    assign cell_end   = hist[1] & ~hist[0];
    assign sample_bit = hist[2];

endmodule

// File: rtl/dacctrl_rx.sv
// rtl/dacctrl_rx.sv - DAC-control stream receiver: frame recovery, header check, shadow registers
module dacctrl_rx
    import dacctrl_pkg::*;
#(
    parameter int PSDAC          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 2 * cell_len(PSDAC)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dacctrl_i,
    output logic        frame_valid_o,
    output logic        frame_err_o,
    output logic [1:0]  addr_o,
    output logic [7:0]  data_o,
    output logic        busy_o,
    output logic [31:0] regs_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state, state_n;
    logic [FRAME_W-1:0] shreg;
    logic [4:0]         cnt;
    logic [TW-1:0]      tcnt;
    logic               cell_end, sample_bit;
    logic               hdr_ok, timeout, valid_n, err_n;
    logic [1:0]         f_addr;
    logic [7:0]         f_data;

    dacctrl_rx_frontend #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_frontend (
        .clk       (clk),
        .rst       (rst),
        .line      (dacctrl_i),
        .cell_end  (cell_end),
        .sample_bit(sample_bit)
    );

    assign hdr_ok = (shreg[FRAME_W-1 -: HDR_W] == HDR) && shreg[MARK_BIT];
    assign f_addr = shreg[ADDR_LSB +: 2];
    assign f_data = shreg[7:0];
    assign busy_o = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // A cell end coincident with the expiry cycle keeps the frame alive.
    always_comb begin
        state_n = state;
        timeout = 1'b0;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (cell_end) state_n = SHIFT;
            end
            SHIFT: begin
                if (cell_end) begin
                    if (cnt == 5'(FRAME_W - 1)) state_n = CHECK;
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            CHECK: begin
                valid_n = hdr_ok;
                err_n   = ~hdr_ok;
                state_n = cell_end ? SHIFT : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg         <= '0;
            cnt           <= '0;
            tcnt          <= '0;
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
            addr_o        <= '0;
            data_o        <= '0;
            regs_o        <= '0;
        end else begin
            frame_valid_o <= valid_n;
            frame_err_o   <= err_n;
            if (cell_end) begin
                shreg <= {shreg[FRAME_W-2:0], sample_bit};
                cnt   <= (state == SHIFT) ? cnt + 5'd1 : 5'd1;
                tcnt  <= '0;
            end else if (state == SHIFT && !timeout) begin
                tcnt <= tcnt + 1'b1;
            end
            if (valid_n) begin
                addr_o                       <= f_addr;
                data_o                       <= f_data;
                regs_o[{f_addr, 3'b000} +: 8] <= f_data;
            end
        end
    end

endmodule

// File: tb/tb_dacctrl_rx.sv
// tb/tb_dacctrl_rx.sv - randomized self-checking bench for dacctrl_rx with a frame-level reference model
module tb_dacctrl_rx;

    localparam int SYNC = 2;
    localparam int CELL = 8;
    localparam int TOUT = 16;
    localparam int LAT  = SYNC + 3;

    typedef struct packed {
        logic        err;
        logic [31:0] cyc;
        logic [1:0]  addr;
        logic [7:0]  data;
        logic [31:0] regs;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line = 1'b0;
    logic        frame_valid_o, frame_err_o, busy_o;
    logic [1:0]  addr_o;
    logic [7:0]  data_o;
    logic [31:0] regs_o;

    int   cyc = 0;
    int   last_low = 0;
    int   both_cnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    ev_t  got[$];
    ev_t  exp_q[$];
    logic [7:0] m_regs [4];
    logic [1:0] m_addr;
    logic [7:0] m_data;

    dacctrl_rx #(
        .PSDAC         (2),
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dacctrl_i    (line),
        .frame_valid_o(frame_valid_o),
        .frame_err_o  (frame_err_o),
        .addr_o       (addr_o),
        .data_o       (data_o),
        .busy_o       (busy_o),
        .regs_o       (regs_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid_o && frame_err_o) both_cnt++;
        if (frame_valid_o || frame_err_o)
            got.push_back(ev_t'({frame_err_o, 32'(cyc), addr_o, data_o, regs_o}));
    end

    function automatic logic [31:0] m_regs_w();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_addr = 2'd0;
        m_data = 8'h00;
    endtask

    // Reference: a frame is good when its top five bits read 31 and bit 8 is set.
    task automatic model_frame(input logic [15:0] w, input int low);
        logic good;
        good = ((w >> 11) == 16'd31) && (((w >> 8) & 16'd1) == 16'd1);
        if (good) begin
            m_addr = 2'((w >> 9) & 16'd3);
            m_data = 8'(w & 16'hFF);
            m_regs[m_addr] = m_data;
        end
        exp_q.push_back(ev_t'({~good, 32'(low + LAT), m_addr, m_data, m_regs_w()}));
    endtask

    task automatic send_cell(input logic b, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            line = (i < len - 2) ? b : (i == len - 2);
        end
        last_low = cyc;
    endtask

    task automatic send_frame(input logic [15:0] w, input bit jit);
        for (int i = 15; i >= 0; i--)
            send_cell(w[i], jit ? CELL - 1 + int'($urandom_range(0, 2)) : CELL);
        model_frame(w, last_low);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        line = 1'b0;
        model_clear();
        repeat (4) @(negedge clk);
        n_checks++;
        if ({frame_valid_o, frame_err_o, busy_o} === 3'b000) n_pass++;
        else $display("FAIL reset_flags got=%b want=000", {frame_valid_o, frame_err_o, busy_o});
        n_checks++;
        if (addr_o === 2'd0) n_pass++;
        else $display("FAIL reset_addr got=%h want=0", addr_o);
        n_checks++;
        if (data_o === 8'h00) n_pass++;
        else $display("FAIL reset_data got=%h want=00", data_o);
        n_checks++;
        if (regs_o === 32'h0) n_pass++;
        else $display("FAIL reset_regs got=%h want=00000000", regs_o);
        rst = 1'b0;
        got.delete();
        repeat (20) @(negedge clk);
        n_checks++;
        if (got.size() == 0 && busy_o === 1'b0) n_pass++;
        else $display("FAIL reset_quiet got events=%0d busy=%b want 0 0", got.size(), busy_o);
    endtask

    task automatic test_single();
        got.delete(); exp_q.delete();
        send_frame(16'hF9C0, 1'b0);
        repeat (12) @(negedge clk);
        n_checks++;
        if (got.size() == exp_q.size()) n_pass++;
        else $display("FAIL single_count got=%0d want=%0d", got.size(), exp_q.size());
        foreach (exp_q[i]) begin
            ev_t g = '1;
            if (i < got.size()) g = got[i];
            n_checks++;
            if (g === exp_q[i]) n_pass++;
            else $display("FAIL single_ev%0d got err=%b cyc=%0d a=%0d d=%h r=%h want err=%b cyc=%0d a=%0d d=%h r=%h",
                          i, g.err, g.cyc, g.addr, g.data, g.regs,
                          exp_q[i].err, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].regs);
        end
        n_checks++;
        if (regs_o === 32'h000000C0) n_pass++;
        else $display("FAIL single_regs got=%h want=000000C0", regs_o);
    endtask

    task automatic test_back_to_back();
        got.delete(); exp_q.delete();
        send_frame(16'hFB80, 1'b0);
        send_frame(16'hFDC0, 1'b0);
        send_frame(16'hFF80, 1'b0);
        repeat (12) @(negedge clk);
        n_checks++;
        if (got.size() == exp_q.size()) n_pass++;
        else $display("FAIL b2b_count got=%0d want=%0d", got.size(), exp_q.size());
        foreach (exp_q[i]) begin
            ev_t g = '1;
            if (i < got.size()) g = got[i];
            n_checks++;
            if (g === exp_q[i]) n_pass++;
            else $display("FAIL b2b_ev%0d got err=%b cyc=%0d a=%0d d=%h r=%h want err=%b cyc=%0d a=%0d d=%h r=%h",
                          i, g.err, g.cyc, g.addr, g.data, g.regs,
                          exp_q[i].err, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].regs);
        end
        n_checks++;
        if (regs_o === 32'h80C080C0) n_pass++;
        else $display("FAIL b2b_regs got=%h want=80C080C0", regs_o);
    endtask

    task automatic test_bad_header();
        got.delete(); exp_q.delete();
        send_frame(16'h79C0, 1'b0);
        send_frame(16'hF8C0, 1'b0);
        repeat (12) @(negedge clk);
        n_checks++;
        if (got.size() == exp_q.size()) n_pass++;
        else $display("FAIL bad_count got=%0d want=%0d", got.size(), exp_q.size());
        foreach (exp_q[i]) begin
            ev_t g = '1;
            if (i < got.size()) g = got[i];
            n_checks++;
            if (g === exp_q[i]) n_pass++;
            else $display("FAIL bad_ev%0d got err=%b cyc=%0d a=%0d d=%h r=%h want err=%b cyc=%0d a=%0d d=%h r=%h",
                          i, g.err, g.cyc, g.addr, g.data, g.regs,
                          exp_q[i].err, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].regs);
        end
        n_checks++;
        if (regs_o === 32'h80C080C0) n_pass++;
        else $display("FAIL bad_regs got=%h want=80C080C0", regs_o);
    endtask

    task automatic test_timeout();
        logic [15:0] w;
        got.delete(); exp_q.delete();
        w = 16'hFB55;
        for (int i = 15; i >= 9; i--) send_cell(w[i], CELL);
        exp_q.push_back(ev_t'({1'b1, 32'(last_low + SYNC + 2 + TOUT), m_addr, m_data, m_regs_w()}));
        repeat (6) @(negedge clk);
        n_checks++;
        if (busy_o === 1'b1) n_pass++;
        else $display("FAIL timeout_busy_mid got=%b want=1", busy_o);
        repeat (30) @(negedge clk);
        n_checks++;
        if (busy_o === 1'b0) n_pass++;
        else $display("FAIL timeout_busy_after got=%b want=0", busy_o);
        send_frame(16'hFB55, 1'b0);
        repeat (12) @(negedge clk);
        n_checks++;
        if (got.size() == exp_q.size()) n_pass++;
        else $display("FAIL timeout_count got=%0d want=%0d", got.size(), exp_q.size());
        foreach (exp_q[i]) begin
            ev_t g = '1;
            if (i < got.size()) g = got[i];
            n_checks++;
            if (g === exp_q[i]) n_pass++;
            else $display("FAIL timeout_ev%0d got err=%b cyc=%0d a=%0d d=%h r=%h want err=%b cyc=%0d a=%0d d=%h r=%h",
                          i, g.err, g.cyc, g.addr, g.data, g.regs,
                          exp_q[i].err, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].regs);
        end
        n_checks++;
        if (addr_o === 2'd1 && data_o === 8'h55) n_pass++;
        else $display("FAIL timeout_next got addr=%0d data=%h want addr=1 data=55", addr_o, data_o);
    endtask

    task automatic test_jitter();
        got.delete(); exp_q.delete();
        send_frame(16'hFDC3, 1'b1);
        repeat (12) @(negedge clk);
        n_checks++;
        if (got.size() == 1 && addr_o === 2'd2 && data_o === 8'hC3) n_pass++;
        else $display("FAIL jitter got events=%0d addr=%0d data=%h want 1 2 c3", got.size(), addr_o, data_o);
    endtask

    task automatic test_random();
        got.delete(); exp_q.delete();
        for (int k = 0; k < 20; k++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                w[15:11] = 5'h1F;
                w[8] = 1'b1;
            end
            send_frame(w, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        n_checks++;
        if (got.size() == exp_q.size()) n_pass++;
        else $display("FAIL random_count got=%0d want=%0d", got.size(), exp_q.size());
        foreach (exp_q[i]) begin
            ev_t g = '1;
            if (i < got.size()) g = got[i];
            n_checks++;
            if (g === exp_q[i]) n_pass++;
            else $display("FAIL random_ev%0d got err=%b cyc=%0d a=%0d d=%h r=%h want err=%b cyc=%0d a=%0d d=%h r=%h",
                          i, g.err, g.cyc, g.addr, g.data, g.regs,
                          exp_q[i].err, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].regs);
        end
        n_checks++;
        if (both_cnt == 0) n_pass++;
        else $display("FAIL exclusive_pulses got both-high cycles=%0d want 0", both_cnt);
    endtask

    task automatic test_stuck_high();
        got.delete();
        @(negedge clk);
        line = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (got.size() == 0 && busy_o === 1'b0) n_pass++;
        else $display("FAIL stuck_high got events=%0d busy=%b want 0 0", got.size(), busy_o);
        line = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] w;
        got.delete(); exp_q.delete();
        w = 16'hFF80;
        for (int i = 15; i >= 6; i--) send_cell(w[i], CELL);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        n_checks++;
        if ({frame_valid_o, frame_err_o, busy_o} === 3'b000 && addr_o === 2'd0 && data_o === 8'h00)
            n_pass++;
        else $display("FAIL midrst_outputs got v=%b e=%b b=%b a=%0d d=%h want all 0",
                      frame_valid_o, frame_err_o, busy_o, addr_o, data_o);
        n_checks++;
        if (regs_o === 32'h0) n_pass++;
        else $display("FAIL midrst_regs got=%h want=00000000", regs_o);
        repeat (30) @(negedge clk);
        n_checks++;
        if (got.size() == 0) n_pass++;
        else $display("FAIL midrst_pulses got=%0d want=0", got.size());
        send_frame(16'hF9AA, 1'b0);
        repeat (12) @(negedge clk);
        n_checks++;
        if (got.size() == 1 && got[0] === exp_q[0]) n_pass++;
        else $display("FAIL midrst_frame got events=%0d want 1 matching %h", got.size(), exp_q[0]);
        n_checks++;
        if (regs_o === 32'h000000AA) n_pass++;
        else $display("FAIL midrst_regs_after got=%h want=000000AA", regs_o);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_header();
        test_timeout();
        test_jitter();
        test_random();
        test_stuck_high();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
